// File: rtl/systolic_tpu.sv
// Output-stationary N x N signed matrix-multiply core.
//
// Each accepted beat carries one column of A (mat_DI, lane i = A[i][k]) and one row of
// B (wei_DI, lane j = B[k][j]). Operands are skewed so that lane i of A enters PE(i,0)
// i cycles late and lane j of B enters PE(0,j) j cycles late; A then shifts right and
// B shifts down one PE per cycle. After the last beat the array is flushed with zero
// operands for 2N-1 cycles, then C is drained one row per cycle on DO, then done rises.
//
// Ports:
//   clk, rst          clock, synchronous active-low reset
//   in_valid/in_ready beat handshake; in_last marks the final k beat of a job
//   mat_DI, wei_DI    A column / B row, N lanes of DATA_W bits
//   out_valid, DO     registered result row (lane j = C[r][j] narrowed to DATA_W)
//   done              level, high while the finished job's results are complete
//
// Build option: define TPU_OUT_SAT_EN to clamp each C element to the signed DATA_W range
// before packing; otherwise the low DATA_W bits of the accumulator are taken.
module systolic_tpu #(
  parameter int unsigned N      = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = 24
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [N*DATA_W-1:0] mat_DI,
  input  logic [N*DATA_W-1:0] wei_DI,
  input  logic                in_last,
  output logic                in_ready,
  output logic                out_valid,
  output logic [N*DATA_W-1:0] DO,
  output logic                done
);

  localparam int unsigned CntW = $clog2(2 * N);
  localparam int unsigned RowW = $clog2(N);

  typedef enum logic [2:0] {StIdle, StAccum, StFlush, StDrain, StDone} state_e;

  state_e                      state_q, state_d;
  logic [CntW-1:0]             cnt_q, cnt_d;
  logic                        out_valid_q, out_valid_d;
  logic [N*DATA_W-1:0]         do_q, do_d;
  logic                        done_q, done_d;
  logic                        accept, clear;

  logic signed [DATA_W-1:0]    a_in [N];
  logic signed [DATA_W-1:0]    b_in [N];
  logic signed [DATA_W-1:0]    a_q  [N][N];
  logic signed [DATA_W-1:0]    b_q  [N][N];
  logic signed [ACC_W-1:0]     acc_q [N][N];
  logic signed [2*DATA_W-1:0]  prod [N][N];

  assign accept = in_valid & in_ready;

  function automatic logic [DATA_W-1:0] narrow(input logic signed [ACC_W-1:0] v);
`ifdef TPU_OUT_SAT_EN
    logic signed [ACC_W-1:0] hi, lo;
    hi = ACC_W'((1 << (DATA_W - 1)) - 1);
    lo = ~hi;
    if (v > hi)      return hi[DATA_W-1:0];
    else if (v < lo) return lo[DATA_W-1:0];
    else             return v[DATA_W-1:0];
`else
    return v[DATA_W-1:0];
`endif
  endfunction

  // Input skew: non-accepted cycles inject zeros, so bubbles and the flush add nothing.
  for (genvar i = 0; i < N; i++) begin : g_skew
    logic [DATA_W-1:0] a_lane, b_lane;
    assign a_lane = accept ? mat_DI[DATA_W*i +: DATA_W] : '0;
    assign b_lane = accept ? wei_DI[DATA_W*i +: DATA_W] : '0;
    if (i == 0) begin : g_direct
      assign a_in[i] = a_lane;
      assign b_in[i] = b_lane;
    end else begin : g_delay
      logic [DATA_W-1:0] a_sk_q [i];
      logic [DATA_W-1:0] b_sk_q [i];
      always_ff @(posedge clk) begin
        if (!rst) begin
          for (int k = 0; k < i; k++) begin
            a_sk_q[k] <= '0;
            b_sk_q[k] <= '0;
          end
        end else begin
          a_sk_q[0] <= a_lane;
          b_sk_q[0] <= b_lane;
          for (int k = 1; k < i; k++) begin
            a_sk_q[k] <= a_sk_q[k-1];
            b_sk_q[k] <= b_sk_q[k-1];
          end
        end
      end
      assign a_in[i] = a_sk_q[i-1];
      assign b_in[i] = b_sk_q[i-1];
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        prod[i][j] = a_q[i][j] * b_q[i][j];
      end
    end
  end

  // PE array: operand registers feed the MAC; the first beat of a job zeroes every
  // accumulator (operands in flight at that edge are still zero).
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          a_q[i][j]   <= '0;
          b_q[i][j]   <= '0;
          acc_q[i][j] <= '0;
        end
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        a_q[i][0] <= a_in[i];
        b_q[0][i] <= b_in[i];
        for (int j = 1; j < N; j++) begin
          a_q[i][j] <= a_q[i][j-1];
          b_q[j][i] <= b_q[j-1][i];
        end
        for (int j = 0; j < N; j++) begin
          acc_q[i][j] <= clear ? '0 : acc_q[i][j] + ACC_W'(prod[i][j]);
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    clear       = 1'b0;
    in_ready    = 1'b0;
    out_valid_d = 1'b0;
    do_d        = do_q;
    done_d      = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        in_ready = 1'b1;
        done_d   = (state_q == StDone);
        if (in_valid) begin
          clear   = 1'b1;
          done_d  = 1'b0;
          cnt_d   = '0;
          state_d = in_last ? StFlush : StAccum;
        end
      end
      StAccum: begin
        in_ready = 1'b1;
        if (in_valid && in_last) begin
          cnt_d   = '0;
          state_d = StFlush;
        end
      end
      StFlush: begin
        // Last operand pair reaches PE(N-1,N-1) 2N-2 edges after the last beat.
        if (cnt_q == CntW'(2 * N - 2)) begin
          cnt_d   = '0;
          state_d = StDrain;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDrain: begin
        out_valid_d = 1'b1;
        for (int j = 0; j < N; j++) begin
          do_d[DATA_W*j +: DATA_W] = narrow(acc_q[cnt_q[RowW-1:0]][j]);
        end
        if (cnt_q == CntW'(N - 1)) begin
          cnt_d   = '0;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      do_q        <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      do_q        <= do_d;
      done_q      <= done_d;
    end
  end

  assign out_valid = out_valid_q;
  assign DO        = do_q;
  assign done      = done_q;

endmodule

// File: tb/tb_systolic_tpu.sv
module tb_systolic_tpu;

  localparam int N    = 4;
  localparam int DW   = 8;
  localparam int KMAX = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic [N*DW-1:0] mat_DI = '0;
  logic [N*DW-1:0] wei_DI = '0;
  logic          in_last = 1'b0;
  logic          in_ready;
  logic          out_valid;
  logic [N*DW-1:0] DO;
  logic          done;

  systolic_tpu dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .mat_DI    (mat_DI),
    .wei_DI    (wei_DI),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .DO        (DO),
    .done      (done)
  );

  initial forever #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  int n_vec = 0;
  int n_fail = 0;

  // Job description and model results.
  int            a_m [N][KMAX];
  int            b_m [KMAX][N];
  int            k_len;
  logic [N*DW-1:0] exp_row [N];

  // Observations.
  logic [N*DW-1:0] obs_do [N];
  int            obs_off [N];
  int            ov_cnt, done_off, e0;
  logic          done_after_first, ready_after_last;

  function automatic logic [7:0] ref_narrow(input int s);
    int s24;
    s24 = (s <<< 8) >>> 8;
`ifdef TPU_OUT_SAT_EN
    if (s24 > 127) s24 = 127;
    if (s24 < -128) s24 = -128;
`endif
    return 8'(s24);
  endfunction

  function automatic void model();
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        int s;
        s = 0;
        for (int k = 0; k < k_len; k++) s += a_m[r][k] * b_m[k][c];
        exp_row[r][DW*c +: DW] = ref_narrow(s);
      end
    end
  endfunction

  function automatic void rand_job(input int k);
    k_len = k;
    for (int kk = 0; kk < k; kk++) begin
      for (int i = 0; i < N; i++) begin
        a_m[i][kk] = int'($urandom_range(255)) - 128;
        b_m[kk][i] = int'($urandom_range(255)) - 128;
      end
    end
  endfunction

  // Entered at a negedge; returns at the negedge after the last beat's edge.
  task automatic drive_beats(input bit bubbles);
    for (int k = 0; k < k_len; k++) begin
      if (bubbles && k > 0) begin
        in_valid = 1'b0;
        in_last  = 1'($urandom_range(1));
        mat_DI   = $urandom;
        wei_DI   = $urandom;
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_last  = (k == k_len - 1);
      for (int i = 0; i < N; i++) begin
        mat_DI[DW*i +: DW] = 8'(a_m[i][k]);
        wei_DI[DW*i +: DW] = 8'(b_m[k][i]);
      end
      @(negedge clk);
      if (k == 0) done_after_first = done;
    end
    e0 = edge_n;
    ready_after_last = in_ready;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Records result rows with their edge offset from the last beat; stops once done is seen.
  task automatic observe(input bit noise);
    ov_cnt = 0;
    done_off = -1;
    for (int r = 0; r < N; r++) begin
      obs_off[r] = -1;
      obs_do[r]  = 'x;
    end
    for (int it = 0; it < 3 * N + 6; it++) begin
      if (noise && (edge_n + 1 - e0) <= 3 * N - 1) begin
        in_valid = 1'($urandom_range(1));
        in_last  = 1'($urandom_range(1));
        mat_DI   = $urandom;
        wei_DI   = $urandom;
      end else begin
        in_valid = 1'b0;
        in_last  = 1'b0;
      end
      @(negedge clk);
      if (out_valid === 1'b1) begin
        if (ov_cnt < N) begin
          obs_do[ov_cnt]  = DO;
          obs_off[ov_cnt] = edge_n - e0;
        end
        ov_cnt++;
      end
      if (done === 1'b1) begin
        done_off = edge_n - e0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || DO !== '0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: in_ready=%b out_valid=%b DO=%h done=%b, want 1 0 0 0",
               in_ready, out_valid, DO, done);
    end
  endtask

  task automatic test_identity();
    logic [N*DW-1:0] want [N];
    want = '{32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D};
    k_len = 4;
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < N; i++) begin
        a_m[i][k] = (i == k) ? 1 : 0;
        b_m[k][i] = 4 * k + i + 1;
      end
    drive_beats(1'b0);
    n_vec++;
    if (ready_after_last !== 1'b0) begin
      n_fail++;
      $display("FAIL identity_flush_ready: in_ready=%b want 0", ready_after_last);
    end
    observe(1'b0);
    for (int r = 0; r < N; r++) begin
      n_vec++;
      if (obs_do[r] !== want[r] || obs_off[r] != 2 * N + r) begin
        n_fail++;
        $display("FAIL identity_row%0d: DO=%h at e0+%0d, want %h at e0+%0d",
                 r, obs_do[r], obs_off[r], want[r], 2 * N + r);
      end
    end
    n_vec++;
    if (ov_cnt != N || done_off != 3 * N) begin
      n_fail++;
      $display("FAIL identity_done: rows=%0d done at e0+%0d, want %0d at e0+%0d",
               ov_cnt, done_off, N, 3 * N);
    end
  endtask

  task automatic test_bubbles();
    logic [N*DW-1:0] want [N];
    want = '{32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D};
    drive_beats(1'b1);
    observe(1'b0);
    for (int r = 0; r < N; r++) begin
      n_vec++;
      if (obs_do[r] !== want[r] || obs_off[r] != 2 * N + r) begin
        n_fail++;
        $display("FAIL bubbles_row%0d: DO=%h at e0+%0d, want %h at e0+%0d",
                 r, obs_do[r], obs_off[r], want[r], 2 * N + r);
      end
    end
    n_vec++;
    if (ov_cnt != N || done_off != 3 * N) begin
      n_fail++;
      $display("FAIL bubbles_done: rows=%0d done at e0+%0d, want %0d at e0+%0d",
               ov_cnt, done_off, N, 3 * N);
    end
  endtask

  task automatic test_k1();
    int bv [N];
    bv = '{1, -3, -2, -1};
    k_len = 1;
    for (int i = 0; i < N; i++) begin
      a_m[i][0] = 2;
      b_m[0][i] = bv[i];
    end
    drive_beats(1'b0);
    observe(1'b0);
    for (int r = 0; r < N; r++) begin
      n_vec++;
      if (obs_do[r] !== 32'hFEFCFA02 || obs_off[r] != 2 * N + r) begin
        n_fail++;
        $display("FAIL k1_row%0d: DO=%h at e0+%0d, want fefcfa02 at e0+%0d",
                 r, obs_do[r], obs_off[r], 2 * N + r);
      end
    end
    n_vec++;
    if (ov_cnt != N || done_off != 3 * N) begin
      n_fail++;
      $display("FAIL k1_done: rows=%0d done at e0+%0d, want %0d at e0+%0d",
               ov_cnt, done_off, N, 3 * N);
    end
  endtask

  task automatic test_saturation();
    int bval [2];
    logic [N*DW-1:0] want [2];
    bval = '{127, -128};
`ifdef TPU_OUT_SAT_EN
    want = '{32'h7F7F7F7F, 32'h80808080};
`else
    want = '{32'h08080808, 32'h00000000};
`endif
    for (int t = 0; t < 2; t++) begin
      k_len = 8;
      for (int k = 0; k < 8; k++)
        for (int i = 0; i < N; i++) begin
          a_m[i][k] = 127;
          b_m[k][i] = bval[t];
        end
      drive_beats(1'b0);
      observe(1'b0);
      for (int r = 0; r < N; r++) begin
        n_vec++;
        if (obs_do[r] !== want[t] || obs_off[r] != 2 * N + r) begin
          n_fail++;
          $display("FAIL sat%0d_row%0d: DO=%h at e0+%0d, want %h at e0+%0d",
                   t, r, obs_do[r], obs_off[r], want[t], 2 * N + r);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 6; t++) begin
      rand_job(int'($urandom_range(KMAX, 1)));
      model();
      drive_beats(1'($urandom_range(1)));
      observe(1'b0);
      for (int r = 0; r < N; r++) begin
        n_vec++;
        if (obs_do[r] !== exp_row[r] || obs_off[r] != 2 * N + r) begin
          n_fail++;
          $display("FAIL random%0d_row%0d: DO=%h at e0+%0d, want %h at e0+%0d",
                   t, r, obs_do[r], obs_off[r], exp_row[r], 2 * N + r);
        end
      end
      n_vec++;
      if (ov_cnt != N || done_off != 3 * N) begin
        n_fail++;
        $display("FAIL random%0d_done: rows=%0d done at e0+%0d, want %0d at e0+%0d",
                 t, ov_cnt, done_off, N, 3 * N);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int job = 0; job < 2; job++) begin
      rand_job(int'($urandom_range(KMAX, 2)));
      model();
      drive_beats(1'b0);
      if (job == 1) begin
        n_vec++;
        if (done_after_first !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_done_fall: done=%b after first beat, want 0", done_after_first);
        end
      end
      observe(1'b1);
      for (int r = 0; r < N; r++) begin
        n_vec++;
        if (obs_do[r] !== exp_row[r] || obs_off[r] != 2 * N + r) begin
          n_fail++;
          $display("FAIL b2b%0d_row%0d: DO=%h at e0+%0d, want %h at e0+%0d",
                   job, r, obs_do[r], obs_off[r], exp_row[r], 2 * N + r);
        end
      end
      n_vec++;
      if (ov_cnt != N || done_off != 3 * N) begin
        n_fail++;
        $display("FAIL b2b%0d_done: rows=%0d done at e0+%0d, want %0d at e0+%0d",
                 job, ov_cnt, done_off, N, 3 * N);
      end
    end
  endtask

  task automatic test_reset_mid_flush();
    int bad;
    rand_job(3);
    drive_beats(1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    bad = 0;
    for (int it = 0; it < 3 * N + 4; it++) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || DO !== '0 || done !== 1'b0 || in_ready !== 1'b1) bad++;
    end
    n_vec++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL reset_mid_flush: %0d cycles with output activity, want 0", bad);
    end
    rand_job(5);
    model();
    drive_beats(1'b0);
    observe(1'b0);
    for (int r = 0; r < N; r++) begin
      n_vec++;
      if (obs_do[r] !== exp_row[r] || obs_off[r] != 2 * N + r) begin
        n_fail++;
        $display("FAIL post_reset_row%0d: DO=%h at e0+%0d, want %h at e0+%0d",
                 r, obs_do[r], obs_off[r], exp_row[r], 2 * N + r);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_identity();
    test_bubbles();
    test_k1();
    test_saturation();
    test_random();
    test_back_to_back();
    test_reset_mid_flush();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
